// File: rtl/ap_result_packer_pkg.sv
// ap_result_packer_pkg: shared widths and packer state encoding
package ap_result_packer_pkg;
  localparam int default_element_width = 32;
  localparam int default_no_of_units = 8;
  typedef enum logic [1:0] {IDLE, COLLECT, LASTWR, FIN} state_e;
endpackage

// File: rtl/ap_result_packer.sv
// ap_result_packer: packs dot-product results into AP memory words and signals run completion
module ap_result_packer
  import ap_result_packer_pkg::*;
#(
  parameter int element_width = default_element_width,
  parameter int no_of_units = default_no_of_units,
  parameter int addr_width = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic [element_width-1:0]             result,
  input  logic                                 result_valid,
  output logic                                 ap_mem_we,
  output logic [addr_width-1:0]                ap_mem_addr,
  output logic [element_width*no_of_units-1:0] ap_mem_wdata,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow_err
);
  localparam int lw = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam logic [lw-1:0] last_lane = lw'(no_of_units - 1);
  state_e state_q, state_d;
  logic [31:0] total_q, total_d, cnt_q, cnt_d;
  logic [lw-1:0] lane_q, lane_d;
  logic [element_width-1:0] lanes_q [no_of_units];
  logic [element_width-1:0] lanes_d [no_of_units];
  logic we_q, we_d, ovf_q, ovf_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [element_width*no_of_units-1:0] wdata_q, wdata_d, word;
  logic accept, last, emit;
  assign accept = state_q == COLLECT && result_valid;
  assign last = cnt_q + 32'd1 == total_q;
  assign emit = accept && (lane_q == last_lane || last);
  always_comb begin
    word = '0;
    for (int k = 0; k < no_of_units; k++)
      word[k*element_width +: element_width] = (lw'(k) == lane_q) ? result : lanes_q[k];
  end
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    cnt_d = cnt_q;
    lane_d = lane_q;
    lanes_d = lanes_q;
    we_d = emit;
    addr_d = we_q ? addr_q + addr_width'(1) : addr_q;
    wdata_d = emit ? word : wdata_q;
    ovf_d = ovf_q | (result_valid && state_q != COLLECT);
    case (state_q)
      IDLE: if (start) begin
        total_d = total;
        cnt_d = '0;
        lane_d = '0;
        lanes_d = '{default: '0};
        addr_d = '0;
        ovf_d = 1'b0;
        state_d = (total == 32'd0) ? FIN : COLLECT;
      end
      COLLECT: if (accept) begin
        cnt_d = cnt_q + 32'd1;
        lane_d = emit ? '0 : lane_q + lw'(1);
        if (emit) lanes_d = '{default: '0};
        else lanes_d[lane_q] = result;
        state_d = last ? LASTWR : COLLECT;
      end
      LASTWR: state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      total_q <= '0;
      cnt_q <= '0;
      lane_q <= '0;
      lanes_q <= '{default: '0};
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      cnt_q <= cnt_d;
      lane_q <= lane_d;
      lanes_q <= lanes_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      ovf_q <= ovf_d;
    end
  end
  assign ap_mem_we = we_q;
  assign ap_mem_addr = addr_q;
  assign ap_mem_wdata = wdata_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign overflow_err = ovf_q;
endmodule
